// File: rtl/seven_segment_readback_encoder_if.sv
// seven_segment_readback_encoder_if: digit input and packed word output of the readback encoder
interface seven_segment_readback_encoder_if #(
  parameter int NUM_DIGITS = 8
);
  logic clear;
  logic seg_valid;
  logic seg_ready;
  logic [6:0] seg_in;
  logic word_valid;
  logic word_ready;
  logic [4*NUM_DIGITS-1:0] word_out;
  logic word_err;
  logic [NUM_DIGITS-1:0] err_mask;
  logic [3:0] digit_cnt;
  modport slave (
    input clear, seg_valid, seg_in, word_ready,
    output seg_ready, word_valid, word_out, word_err, err_mask, digit_cnt
  );
  modport master (
    output clear, seg_valid, seg_in, word_ready,
    input seg_ready, word_valid, word_out, word_err, err_mask, digit_cnt
  );
endinterface

// File: rtl/seven_segment_readback_encoder.sv
// seven_segment_readback_encoder: maps active-low 7-segment digits back to hex nibbles and packs them into words
module seven_segment_readback_encoder #(
  parameter int NUM_DIGITS = 8,
  parameter bit BLANK_AS_ZERO = 1'b0
) (
  input logic clk,
  input logic rst_n,
  seven_segment_readback_encoder_if.slave bus
);
  localparam int W = 4 * NUM_DIGITS;
  typedef enum logic {COLLECT, HOLD} state_t;
  state_t state;
  logic [W-1:0] word_out;
  logic [NUM_DIGITS-1:0] err_mask;
  logic [3:0] digit_cnt;
  logic [3:0] nib;
  logic bad;
  // pattern-to-nibble lookup; blank and unknown patterns decode to nibble 0
  always_comb begin
    nib = 4'h0;
    bad = 1'b0;
    case (bus.seg_in)
      7'h40: nib = 4'h0;
      7'h79: nib = 4'h1;
      7'h24: nib = 4'h2;
      7'h30: nib = 4'h3;
      7'h19: nib = 4'h4;
      7'h12: nib = 4'h5;
      7'h02: nib = 4'h6;
      7'h78: nib = 4'h7;
      7'h00: nib = 4'h8;
      7'h10: nib = 4'h9;
      7'h08: nib = 4'hA;
      7'h03: nib = 4'hB;
      7'h46: nib = 4'hC;
      7'h21: nib = 4'hD;
      7'h06: nib = 4'hE;
      7'h0E: nib = 4'hF;
      7'h7F: bad = ~BLANK_AS_ZERO;
      default: bad = 1'b1;
    endcase
  end
  // collect digits MS-first until the word is full, then hold it until the consumer takes it; clear aborts like reset
  always_ff @(posedge clk) begin
    if (!rst_n || bus.clear) begin
      state <= COLLECT;
      word_out <= '0;
      err_mask <= '0;
      digit_cnt <= 4'd0;
    end else if (state == COLLECT) begin
      if (bus.seg_valid) begin
        word_out <= W'({word_out, nib});
        err_mask <= NUM_DIGITS'({err_mask, bad});
        digit_cnt <= digit_cnt + 4'd1;
        state <= digit_cnt == 4'(NUM_DIGITS - 1) ? HOLD : COLLECT;
      end
    end else if (bus.word_ready) begin
      state <= COLLECT;
      word_out <= '0;
      err_mask <= '0;
      digit_cnt <= 4'd0;
    end
  end
  assign bus.seg_ready = state == COLLECT;
  assign bus.word_valid = state == HOLD;
  assign bus.word_out = word_out;
  assign bus.err_mask = err_mask;
  assign bus.word_err = |err_mask;
  assign bus.digit_cnt = digit_cnt;
endmodule
